// File: rtl/parallel2serial_pkg.sv
// Shared constants for the banner transmit path serializer.
// Holds the state encoding and the counter-width helper.
package parallel2serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } p2s_state_t;

  // A single-word load still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parallel2serial_if.sv
// Word stream from the serializer to its consumer (valid/ready handshake).
interface parallel2serial_if #(
  parameter int W = 8
);
  logic [W-1:0] data_out;
  logic         out_valid;
  logic         out_ready;

  modport master (output data_out, output out_valid, input out_ready);
  modport slave  (input data_out, input out_valid, output out_ready);
endinterface

// File: rtl/parallel2serial.sv
// Splits a wide word into N sub-words of W bits, most significant first,
// over a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for start; data_out is stale
// SEND  | presenting sub-word cnt, advancing on each transfer
module parallel2serial
  import parallel2serial_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [W*N-1:0]         data_in,
  input  logic                   start,
  output logic                   busy,
  output logic                   done_tick,
  parallel2serial_if.master      stream
);

  localparam int              CW   = cnt_width(N);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  p2s_state_t      state;
  logic [W*N-1:0]  shreg;
  logic [CW-1:0]   cnt;
  logic            valid_q;
  logic            xfer;

  assign xfer             = valid_q & stream.out_ready;
  assign stream.data_out  = shreg[W*N-1 -: W];
  assign stream.out_valid = valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      valid_q   <= 1'b0;
      busy      <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= data_in;
            cnt     <= '0;
            state   <= SEND;
            valid_q <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SEND: begin
          if (xfer) begin
            // Last word stays in place; data_out is meaningless once idle.
            if (cnt == LAST) begin
              state     <= IDLE;
              valid_q   <= 1'b0;
              busy      <= 1'b0;
              done_tick <= 1'b1;
            end else begin
              shreg <= shreg << W;
              cnt   <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel2serial.sv
// Self-checking bench for parallel2serial: directed cases plus a randomized
// loopback that reassembles the word stream and compares with each load.
module tb_parallel2serial;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] data_in;
  logic        busy, done_tick;

  logic        reset1, start1;
  logic [3:0]  data_in1;
  logic        busy1, done1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  parallel2serial_if #(.W(8)) s8 ();
  parallel2serial_if #(.W(4)) s4 ();

  parallel2serial #(.W(8), .N(4)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .start(start),
    .busy(busy), .done_tick(done_tick), .stream(s8)
  );

  parallel2serial #(.W(4), .N(1)) dut1 (
    .clk(clk), .reset(reset1), .data_in(data_in1), .start(start1),
    .busy(busy1), .done_tick(done1), .stream(s4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sub-word k of a 4x8 load, k=0 being the most significant byte.
  function automatic logic [7:0] exp_word(input logic [31:0] d, input int k);
    return 8'(d >> (8 * (3 - k)));
  endfunction

  int bp_pat [7] = '{1, 0, 0, 1, 0, 1, 1};

  initial begin
    int          widx;
    int          nxfer;
    int          guard;
    int          dones;
    logic [31:0] d;
    logic [31:0] acc;

    reset = 1'b1; start = 1'b0; data_in = '0; s8.out_ready = 1'b0;
    reset1 = 1'b1; start1 = 1'b0; data_in1 = '0; s4.out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", s8.out_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done_tick, 0);
    chk("rst_data",  s8.data_out, 0);
    reset = 1'b0; reset1 = 1'b0;
    tick();
    chk("idle_valid", s8.out_valid, 0);

    // Basic run, ready held high
    data_in = 32'h41424344; start = 1'b1; s8.out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("basic_valid", s8.out_valid, 1);
      chk("basic_busy",  busy, 1);
      chk("basic_data",  s8.data_out, exp_word(32'h41424344, k));
      chk("basic_nodone", done_tick, 0);
      tick();
    end
    chk("basic_done",   done_tick, 1);
    chk("basic_end_bsy", busy, 0);
    chk("basic_end_vld", s8.out_valid, 0);
    tick();
    chk("basic_done_once", done_tick, 0);

    // Backpressure
    start = 1'b1; s8.out_ready = 1'b0;
    tick();
    start = 1'b0;
    widx = 0;
    dones = 0;
    for (int i = 0; i < 7; i++) begin
      s8.out_ready = bp_pat[i][0];
      chk("bp_valid", s8.out_valid, 1);
      chk("bp_data",  s8.data_out, exp_word(32'h41424344, widx));
      if (done_tick) dones++;
      if (bp_pat[i] != 0) widx++;
      tick();
    end
    chk("bp_done", done_tick, 1);
    chk("bp_idle", s8.out_valid, 0);
    if (done_tick) dones++;
    tick();
    if (done_tick) dones++;
    chk("bp_one_done", dones, 1);

    // Start while busy is ignored; start during done cycle is accepted
    s8.out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("sb_w0", s8.data_out, 8'h41);
    tick();
    chk("sb_w1", s8.data_out, 8'h42);
    data_in = 32'h51525354; start = 1'b1;
    tick();
    chk("sb_w2", s8.data_out, 8'h43);
    tick();
    start = 1'b0;
    chk("sb_w3", s8.data_out, 8'h44);
    tick();
    chk("sb_done", done_tick, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_valid", s8.out_valid, 1);
    chk("b2b_busy",  busy, 1);
    for (int k = 0; k < 4; k++) begin
      chk("b2b_data", s8.data_out, exp_word(32'h51525354, k));
      tick();
    end
    chk("b2b_done", done_tick, 1);
    tick();

    // Reset after the second transfer
    data_in = 32'h41424344; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rm_w0", s8.data_out, 8'h41);
    tick();
    chk("rm_w1", s8.data_out, 8'h42);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_valid", s8.out_valid, 0);
    chk("rm_busy",  busy, 0);
    chk("rm_data",  s8.data_out, 0);
    chk("rm_done",  done_tick, 0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_tick) dones++;
    end
    chk("rm_no_done", dones, 0);
    data_in = 32'h61626364; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rm_restart", s8.data_out, exp_word(32'h61626364, k));
      tick();
    end
    chk("rm_restart_done", done_tick, 1);
    tick();

    // Single-word instance
    data_in1 = 4'hA; start1 = 1'b1; s4.out_ready = 1'b1;
    tick();
    start1 = 1'b0;
    chk("n1_valid", s4.out_valid, 1);
    chk("n1_busy",  busy1, 1);
    chk("n1_data",  s4.data_out, 4'hA);
    tick();
    chk("n1_done",  done1, 1);
    chk("n1_idle",  s4.out_valid, 0);
    tick();
    chk("n1_done_once", done1, 0);

    // Randomized loopback: reassemble transfers MSB-first
    for (int w = 0; w < 100; w++) begin
      d = $urandom;
      data_in = d; start = 1'b1;
      tick();
      start = 1'b0;
      data_in = $urandom;
      acc = '0; nxfer = 0; guard = 0;
      while (nxfer < 4 && guard < 200) begin
        s8.out_ready = 1'($urandom_range(0, 1));
        chk("lb_valid", s8.out_valid, 1);
        chk("lb_data",  s8.data_out, exp_word(d, nxfer));
        if (s8.out_ready) begin
          acc = (acc << 8) | 32'(s8.data_out);
          nxfer++;
        end
        tick();
        guard++;
      end
      chk("lb_in_budget", guard < 200, 1);
      chk("lb_done", done_tick, 1);
      chk("lb_word", acc, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
